// File: rtl/ecap5_dproc_pkg.sv
// Shared types and constants for the ecap5 data-processor front end.
package ecap5_dproc_pkg;

  localparam logic [31:0] BOOT_ADDRESS_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    REQUEST  = 2'd0,
    WAIT_ACK = 2'd1,
    HOLD     = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch.sv
// Instruction fetch: one outstanding Wishbone B4 pipelined read at a time,
// one-entry output register plus a one-entry skid for back-pressure.
module fetch import ecap5_dproc_pkg::*; #(
  parameter logic [31:0] BOOT_ADDRESS = BOOT_ADDRESS_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        output_ready_i,
  output logic        output_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,

  input  logic        branch_i,
  input  logic [31:0] branch_target_i,

  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_stall_i
);

  fetch_state_t r_state, w_next_state;
  logic [31:0]  r_fetch_pc, w_next_fetch_pc;
  logic         r_discard, w_next_discard;
  logic [31:0]  r_skid_instr;
  logic         r_valid;
  logic [31:0]  r_instr, r_pc;

  logic         w_cyc, w_stb;
  logic         w_load_out, w_load_skid;
  logic [31:0]  w_load_data;
  logic         w_can_load;
  logic [31:0]  w_target;

  assign w_target   = branch_target_i & ~32'h0000_0003;
  assign w_can_load = !r_valid || output_ready_i;

  always_comb begin
    w_next_state    = r_state;
    w_next_fetch_pc = r_fetch_pc;
    w_next_discard  = r_discard;
    w_load_out      = 1'b0;
    w_load_skid     = 1'b0;
    w_load_data     = wb_dat_i;
    w_cyc           = 1'b0;
    w_stb           = 1'b0;
    case (r_state)
      REQUEST: begin
        w_cyc = 1'b1;
        w_stb = 1'b1;
        if (branch_i) begin
          w_next_fetch_pc = w_target;
          // A strobe the slave took this cycle will still be acked: wait for it and drop it.
          if (!wb_stall_i) begin
            w_next_state   = WAIT_ACK;
            w_next_discard = 1'b1;
          end
        end else if (!wb_stall_i) begin
          w_next_state = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        w_cyc = 1'b1;
        if (branch_i) begin
          w_next_fetch_pc = w_target;
          if (wb_ack_i) begin
            w_next_state   = REQUEST;
            w_next_discard = 1'b0;
          end else begin
            w_next_discard = 1'b1;
          end
        end else if (wb_ack_i) begin
          w_next_state   = REQUEST;
          w_next_discard = 1'b0;
          if (!r_discard) begin
            if (w_can_load) begin
              w_load_out      = 1'b1;
              w_next_fetch_pc = r_fetch_pc + 32'd4;
            end else begin
              w_load_skid  = 1'b1;
              w_next_state = HOLD;
            end
          end
        end
      end
      HOLD: begin
        if (branch_i) begin
          w_next_fetch_pc = w_target;
          w_next_state    = REQUEST;
        end else if (w_can_load) begin
          w_load_out      = 1'b1;
          w_load_data     = r_skid_instr;
          w_next_fetch_pc = r_fetch_pc + 32'd4;
          w_next_state    = REQUEST;
        end
      end
      default: w_next_state = REQUEST;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= REQUEST;
      r_fetch_pc   <= BOOT_ADDRESS;
      r_discard    <= 1'b0;
      r_skid_instr <= '0;
      r_valid      <= 1'b0;
      r_instr      <= '0;
      r_pc         <= '0;
    end else begin
      r_state    <= w_next_state;
      r_fetch_pc <= w_next_fetch_pc;
      r_discard  <= w_next_discard;
      if (w_load_skid) r_skid_instr <= wb_dat_i;
      if (branch_i) begin
        r_valid <= 1'b0;
      end else if (w_load_out) begin
        r_valid <= 1'b1;
        r_instr <= w_load_data;
        r_pc    <= r_fetch_pc;
      end else if (output_ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  // Bus request is gated by reset so nothing is strobed while the state register is stale.
  assign wb_cyc_o = w_cyc && !rst_i;
  assign wb_stb_o = w_stb && !rst_i;
  assign wb_adr_o = rst_i ? '0 : r_fetch_pc;
  assign wb_sel_o = 4'b1111;
  assign wb_we_o  = 1'b0;

  assign output_valid_o = r_valid;
  assign instr_o        = r_instr;
  assign pc_o           = r_pc;

endmodule

// File: tb/tb_fetch.sv
// Randomized scoreboard bench for fetch: behavioural slave, expected-PC queue, decoupled monitor.
module tb_fetch;

  localparam logic [31:0] TB_BOOT = 32'hFFFF_FFF8;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        output_ready_i;
  logic        output_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        branch_i;
  logic [31:0] branch_target_i;
  logic [31:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_stall_i;

  fetch #(.BOOT_ADDRESS(TB_BOOT)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .output_ready_i (output_ready_i),
    .output_valid_o (output_valid_o),
    .instr_o        (instr_o),
    .pc_o           (pc_o),
    .branch_i       (branch_i),
    .branch_target_i(branch_target_i),
    .wb_adr_o       (wb_adr_o),
    .wb_sel_o       (wb_sel_o),
    .wb_we_o        (wb_we_o),
    .wb_stb_o       (wb_stb_o),
    .wb_cyc_o       (wb_cyc_o),
    .wb_dat_i       (wb_dat_i),
    .wb_ack_i       (wb_ack_i),
    .wb_stall_i     (wb_stall_i)
  );

  always #5 clk_i = ~clk_i;

  // Memory contents seen by the slave: a fixed function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Scoreboard: PCs the consumer should see, in order.
  logic [31:0] exp_q[$];
  logic [31:0] exp_next;
  int          phase = 0;

  // Driver / slave state
  logic        s_pend;
  int          s_wait;
  logic [31:0] s_adr;
  logic        k_stall, k_rdy_rand, k_branch, k_hold;
  int          k_maxwait;

  // Monitor state and counters
  int          total = 0;
  int          bad = 0;
  int          hs1 = 0;
  int          hs_all = 0;
  int          m_phase = 0;
  logic        m_pend = 1'b0;
  logic        p_rst = 1'b0, p_valid = 1'b0, p_ready = 1'b0, p_branch = 1'b0, p_stallreq = 1'b0;
  logic [31:0] p_pc = '0, p_instr = '0, p_adr = '0, m_e;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (t=%0t)", name, got, want, $time);
    end
  endtask

  // One clock of stimulus: sample bus at negedge, update model at posedge, drive at posedge+1.
  task automatic cycle();
    logic acc, ackd;
    logic [31:0] adr;
    @(negedge clk_i);
    acc  = wb_cyc_o && wb_stb_o && !wb_stall_i;
    ackd = wb_ack_i;
    adr  = wb_adr_o;
    @(posedge clk_i);
    if (branch_i) begin
      exp_q.delete();
      exp_next = branch_target_i & ~32'h3;
    end
    if (rst_i) begin
      exp_q.delete();
      exp_next = TB_BOOT;
      s_pend   = 1'b0;
    end
    while (exp_q.size() < 16) begin
      exp_q.push_back(exp_next);
      exp_next = exp_next + 32'd4;
    end
    #1;
    if (ackd) s_pend = 1'b0;
    if (acc && !rst_i) begin
      s_pend = 1'b1;
      s_adr  = adr;
      s_wait = $urandom_range(0, k_maxwait);
    end
    wb_ack_i = 1'b0;
    wb_dat_i = $urandom;
    if (s_pend && !k_hold) begin
      if (s_wait == 0) begin
        wb_ack_i = 1'b1;
        wb_dat_i = mem_word(s_adr);
      end else begin
        s_wait--;
      end
    end
    wb_stall_i      = k_stall && ($urandom_range(0, 3) == 0);
    output_ready_i  = k_rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    branch_i        = k_branch && ($urandom_range(0, 24) == 0);
    branch_target_i = ($urandom_range(0, 3) == 0) ? {28'hFFFF_FFF, 4'($urandom_range(0, 15))}
                                                  : {16'h0000, 16'($urandom_range(0, 65535))};
  endtask

  // Driver
  initial begin
    rst_i = 1'b1; output_ready_i = 1'b1; branch_i = 1'b0; branch_target_i = '0;
    wb_ack_i = 1'b0; wb_stall_i = 1'b0; wb_dat_i = '0;
    s_pend = 1'b0; s_wait = 0; s_adr = '0; exp_next = TB_BOOT;
    k_stall = 1'b0; k_rdy_rand = 1'b0; k_branch = 1'b0; k_hold = 1'b0; k_maxwait = 0;

    repeat (3) cycle();
    rst_i = 1'b0;
    phase = 1;
    repeat (40) cycle();

    // Reset while waiting for an ack; ack arrives during reset and once more just after.
    phase  = 2;
    k_hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (wb_cyc_o && !wb_stb_o) break;
    end
    rst_i = 1'b1; wb_ack_i = 1'b1; wb_dat_i = 32'hDEAD_BEEF;
    cycle();
    rst_i = 1'b1; wb_ack_i = 1'b1; wb_dat_i = 32'hDEAD_BEEF;
    cycle();
    rst_i = 1'b0; wb_ack_i = 1'b1; wb_stall_i = 1'b1; wb_dat_i = 32'hDEAD_BEEF;
    cycle();
    k_hold = 1'b0;

    phase = 3;
    k_stall = 1'b1; k_rdy_rand = 1'b1; k_branch = 1'b1; k_maxwait = 2;
    repeat (3000) cycle();

    phase = 9;
    repeat (50) cycle();
    $display("FAIL timeout: monitor never reached the summary");
    $fatal(1, "bench did not terminate");
  end

  // Monitor
  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
        chk("rst_stb", 32'(wb_stb_o), 32'd0);
        chk("rst_adr", wb_adr_o, 32'd0);
        if (p_rst) begin
          chk("rst_valid", 32'(output_valid_o), 32'd0);
          chk("rst_instr", instr_o, 32'd0);
          chk("rst_pc", pc_o, 32'd0);
        end
      end else begin
        if (p_rst) begin
          chk("first_stb", 32'(wb_stb_o), 32'd1);
          chk("first_adr", wb_adr_o, TB_BOOT);
        end
        if (wb_cyc_o) begin
          chk("we_zero", 32'(wb_we_o), 32'd0);
          chk("sel_all", 32'(wb_sel_o), 32'hF);
        end
        if (wb_stb_o) chk("stb_needs_cyc", 32'(wb_cyc_o), 32'd1);
        if (p_stallreq && !p_branch) begin
          chk("stall_stb_held", 32'(wb_stb_o), 32'd1);
          chk("stall_adr_held", wb_adr_o, p_adr);
        end
        if (p_valid && !p_ready && !p_branch && !p_rst) begin
          chk("hold_valid", 32'(output_valid_o), 32'd1);
          chk("hold_pc", pc_o, p_pc);
          chk("hold_instr", instr_o, p_instr);
        end
        if (wb_cyc_o && wb_stb_o && !wb_stall_i)
          chk("one_outstanding", 32'(m_pend && !wb_ack_i), 32'd0);
        if (output_valid_o && output_ready_i) begin
          hs_all++;
          if (phase == 1) hs1++;
          if (exp_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
          end else begin
            m_e = exp_q.pop_front();
            chk("out_pc", pc_o, m_e);
            chk("out_instr", instr_o, mem_word(m_e));
          end
        end
      end

      if (m_phase == 1 && phase != 1) chk("throughput_40cyc", 32'(hs1), 32'd19);

      m_pend     = rst_i ? 1'b0 : ((m_pend && !wb_ack_i) || (wb_cyc_o && wb_stb_o && !wb_stall_i));
      p_rst      = rst_i;
      p_valid    = output_valid_o;
      p_ready    = output_ready_i;
      p_branch   = branch_i;
      p_stallreq = !rst_i && wb_stb_o && wb_stall_i;
      p_adr      = wb_adr_o;
      p_pc       = pc_o;
      p_instr    = instr_o;
      m_phase    = phase;

      if (phase == 9) begin
        chk("delivered_enough", 32'(hs_all >= 100), 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  end

endmodule
